// File: rtl/elastic_buffer_pkg.sv
// rtl/elastic_buffer_pkg.sv - shared SKP symbols, watermark defaults and helpers for the RX elastic buffer
package elastic_buffer_pkg;

    localparam logic [9:0] SKP_RDN = 10'b001111_1001;
    localparam logic [9:0] SKP_RDP = 10'b110000_0110;

    localparam int DATA_WIDTH_DEF   = 10;
    localparam int BUFFER_DEPTH_DEF = 16;
    localparam int HIGH_WM_HF_DEF   = 10;
    localparam int LOW_WM_HF_DEF    = 6;
    localparam int HIGH_WM_NE_DEF   = 4;
    localparam int LOW_WM_NE_DEF    = 1;

    typedef enum logic {
        BUF_MODE_NE = 1'b0,
        BUF_MODE_HF = 1'b1
    } buf_mode_e;

    function automatic logic is_skp_sym(input logic [9:0] sym);
        return (sym == SKP_RDN) || (sym == SKP_RDP);
    endfunction

endpackage

// File: rtl/gray_sync_2ff.sv
// rtl/gray_sync_2ff.sv - two-flop synchroniser for a Gray pointer with Gray->binary conversion
module gray_sync_2ff #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] gray_in,
    output logic [W-1:0] bin_out
);

    logic [W-1:0] sync1_d, sync1_q;
    logic [W-1:0] sync2_d, sync2_q;

    always_comb begin
        sync1_d = gray_in;
        sync2_d = sync1_q;
        bin_out = '0;
        // Each binary bit is the XOR of all Gray bits at and above it.
        for (int i = 0; i < W; i++) begin
            bin_out[i] = ^(sync2_q >> i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

endmodule

// File: rtl/write_pointer_control.sv
// rtl/write_pointer_control.sv - elastic buffer write side; EB_SKP_STATS_EN adds SKP-delete/overflow counters
module write_pointer_control
    import elastic_buffer_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int BUFFER_DEPTH = BUFFER_DEPTH_DEF,
    parameter int HIGH_WM_HF   = HIGH_WM_HF_DEF,
    parameter int LOW_WM_HF    = LOW_WM_HF_DEF,
    parameter int HIGH_WM_NE   = HIGH_WM_NE_DEF,
    parameter int LOW_WM_NE    = LOW_WM_NE_DEF,
    localparam int AW          = $clog2(BUFFER_DEPTH)
) (
    input  logic                  write_clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    input  logic                  buffer_mode,
    input  logic [AW:0]           gray_read_pointer,
    output logic                  write_enable,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic [AW:0]           write_address,
    output logic [AW:0]           gray_write_pointer,
    output logic                  full,
    output logic                  add_req,
    output logic                  skp_removed,
`ifdef EB_SKP_STATS_EN
    output logic [7:0]            skp_del_count,
    output logic [7:0]            ovf_count,
`endif
    output logic                  overflow
);

    localparam int PW = AW + 1;

    logic [AW:0] rd_sync;
    logic [AW:0] fill, high_wm, low_wm;
    logic        is_skp, del, accept;
    buf_mode_e   mode;

    logic [AW:0] write_address_d, write_address_q;
    logic [AW:0] gray_write_pointer_d, gray_write_pointer_q;
    logic        add_req_d, add_req_q;
    logic        skp_removed_d, skp_removed_q;
    logic        overflow_d, overflow_q;
    logic        del_done_d, del_done_q;
`ifdef EB_SKP_STATS_EN
    logic [7:0]  skp_del_count_d, skp_del_count_q;
    logic [7:0]  ovf_count_d, ovf_count_q;
`endif

    gray_sync_2ff #(.W(PW)) u_rd_sync (
        .clk     (write_clk),
        .rst_n   (rst_n),
        .gray_in (gray_read_pointer),
        .bin_out (rd_sync)
    );

    always_comb begin
        mode = buf_mode_e'(buffer_mode);
        // Modulo subtraction keeps fill correct across pointer wrap.
        fill = write_address_q - rd_sync;
        full = (fill == PW'(BUFFER_DEPTH));
        if (mode == BUF_MODE_HF) begin
            high_wm = PW'(HIGH_WM_HF);
            low_wm  = PW'(LOW_WM_HF);
        end else begin
            high_wm = PW'(HIGH_WM_NE);
            low_wm  = PW'(LOW_WM_NE);
        end
        is_skp = is_skp_sym(data_in);
        del    = data_valid & is_skp & (fill >= high_wm) & ~del_done_q;
        accept = data_valid & ~del & ~full;

        write_address_d      = write_address_q + PW'(accept);
        gray_write_pointer_d = write_address_q ^ (write_address_q >> 1);
        add_req_d            = (fill <= low_wm);
        skp_removed_d        = del;
        overflow_d           = data_valid & ~del & full;

        del_done_d = del_done_q;
        if (del) begin
            del_done_d = 1'b1;
        end else if (data_valid && !is_skp) begin
            del_done_d = 1'b0;
        end
`ifdef EB_SKP_STATS_EN
        skp_del_count_d = skp_del_count_q;
        if (skp_removed_q && (skp_del_count_q != 8'hFF)) begin
            skp_del_count_d = skp_del_count_q + 8'd1;
        end
        ovf_count_d = ovf_count_q;
        if (overflow_q && (ovf_count_q != 8'hFF)) begin
            ovf_count_d = ovf_count_q + 8'd1;
        end
`endif
    end

    always_ff @(posedge write_clk or negedge rst_n) begin
        if (!rst_n) begin
            write_address_q      <= '0;
            gray_write_pointer_q <= '0;
            add_req_q            <= 1'b0;
            skp_removed_q        <= 1'b0;
            overflow_q           <= 1'b0;
            del_done_q           <= 1'b0;
`ifdef EB_SKP_STATS_EN
            skp_del_count_q      <= '0;
            ovf_count_q          <= '0;
`endif
        end else begin
            write_address_q      <= write_address_d;
            gray_write_pointer_q <= gray_write_pointer_d;
            add_req_q            <= add_req_d;
            skp_removed_q        <= skp_removed_d;
            overflow_q           <= overflow_d;
            del_done_q           <= del_done_d;
`ifdef EB_SKP_STATS_EN
            skp_del_count_q      <= skp_del_count_d;
            ovf_count_q          <= ovf_count_d;
`endif
        end
    end

    assign write_enable       = accept;
    assign write_data         = data_in;
    assign write_address      = write_address_q;
    assign gray_write_pointer = gray_write_pointer_q;
    assign add_req            = add_req_q;
    assign skp_removed        = skp_removed_q;
    assign overflow           = overflow_q;
`ifdef EB_SKP_STATS_EN
    assign skp_del_count      = skp_del_count_q;
    assign ovf_count          = ovf_count_q;
`endif

endmodule
